// File: rtl/traffic_pkg.sv
// Shared traffic types: pedestrian FSM states, car-park capacity
// default and light codes common to frontend and controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_PENDING = 2'd1,
    P_SERVING = 2'd2
  } ped_state_t;

  localparam int MAX_SLOTS_DEF = 10;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer;
// the filtered level flips after DEBOUNCE_CYCLES differing cycles.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_request_frontend.sv
// Field-signal front-end for the traffic controller.
// Optional emergency hold: define FRONTEND_EMERG_HOLD_EN.
module traffic_request_frontend
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EMERG_HOLD      = 8,
  parameter int MAX_SLOTS       = MAX_SLOTS_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_ped_raw,
  input  logic       siren_raw,
  input  logic       loop_car_raw,
  input  logic       gate_in_raw,
  input  logic       gate_out_raw,
  input  logic       pedestrian_green,
  input  logic [3:0] parking_slots,
  output logic       pedestrian_req,
  output logic       emergency,
  output logic       car_sensor,
  output logic       car_enter,
  output logic       car_exit,
  output logic       parking_full
);

  if (EMERG_HOLD < 1) begin : g_bad_hold
    $error("EMERG_HOLD must be at least 1");
  end

  logic btn_f, siren_f, loop_f, gin_f, gout_f;
  logic btn_q, gin_q, gout_q;
  logic exit_pending;
  ped_state_t p_state;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(clk), .reset_n(reset_n), .raw(btn_ped_raw), .level(btn_f));
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_siren (
    .clk(clk), .reset_n(reset_n), .raw(siren_raw), .level(siren_f));
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loop (
    .clk(clk), .reset_n(reset_n), .raw(loop_car_raw), .level(loop_f));
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_gin (
    .clk(clk), .reset_n(reset_n), .raw(gate_in_raw), .level(gin_f));
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_gout (
    .clk(clk), .reset_n(reset_n), .raw(gate_out_raw), .level(gout_f));

  logic btn_rise, gin_rise, gout_rise;
  logic enter_ok, exit_ok;

  assign btn_rise  = btn_f & ~btn_q;
  assign gin_rise  = gin_f & ~gin_q;
  assign gout_rise = gout_f & ~gout_q;
  assign enter_ok  = (parking_slots != 4'd0);
  assign exit_ok   = (32'(parking_slots) < MAX_SLOTS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q          <= 1'b0;
      p_state        <= P_IDLE;
      pedestrian_req <= 1'b0;
    end else begin
      btn_q <= btn_f;
      unique case (p_state)
        P_IDLE: if (btn_rise) begin
          p_state        <= P_PENDING;
          pedestrian_req <= 1'b1;
        end
        P_PENDING: if (pedestrian_green) begin
          p_state        <= P_SERVING;
          pedestrian_req <= 1'b0;
        end
        P_SERVING: if (!pedestrian_green) begin
          p_state <= P_IDLE;
        end
        default: begin
          p_state        <= P_IDLE;
          pedestrian_req <= 1'b0;
        end
      endcase
    end
  end

  // A simultaneous exit is deferred one cycle so the pulses never overlap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gin_q        <= 1'b0;
      gout_q       <= 1'b0;
      exit_pending <= 1'b0;
      car_enter    <= 1'b0;
      car_exit     <= 1'b0;
      car_sensor   <= 1'b0;
      parking_full <= 1'b0;
    end else begin
      gin_q        <= gin_f;
      gout_q       <= gout_f;
      car_sensor   <= loop_f;
      parking_full <= (parking_slots == 4'd0);
      if (gin_rise && gout_rise) begin
        car_enter    <= enter_ok;
        car_exit     <= 1'b0;
        exit_pending <= 1'b1;
      end else if (exit_pending) begin
        car_enter    <= 1'b0;
        car_exit     <= exit_ok;
        exit_pending <= 1'b0;
      end else begin
        car_enter <= gin_rise & enter_ok;
        car_exit  <= gout_rise & exit_ok;
      end
    end
  end

`ifdef FRONTEND_EMERG_HOLD_EN
  localparam int HW = $clog2(EMERG_HOLD + 1);

  logic          siren_q;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_next;

  always_comb begin
    hold_next = hold;
    if (siren_f) begin
      hold_next = '0;
    end else if (siren_q) begin
      hold_next = HW'(EMERG_HOLD);
    end else if (hold != '0) begin
      hold_next = hold - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      siren_q   <= 1'b0;
      hold      <= '0;
      emergency <= 1'b0;
    end else begin
      siren_q   <= siren_f;
      hold      <= hold_next;
      emergency <= siren_f | (hold_next != '0);
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      emergency <= 1'b0;
    end else begin
      emergency <= siren_f;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_request_frontend.sv
// Directed bench for traffic_request_frontend (DEBOUNCE_CYCLES=4).
// Hold expectations follow FRONTEND_EMERG_HOLD_EN when defined.
module tb_traffic_request_frontend;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int LAT  = DEB + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_ped_raw = 1'b0;
  logic       siren_raw = 1'b0;
  logic       loop_car_raw = 1'b0;
  logic       gate_in_raw = 1'b0;
  logic       gate_out_raw = 1'b0;
  logic       pedestrian_green = 1'b0;
  logic [3:0] parking_slots = 4'd5;
  logic       pedestrian_req;
  logic       emergency;
  logic       car_sensor;
  logic       car_enter;
  logic       car_exit;
  logic       parking_full;

  int errors = 0;
  int checks = 0;

  traffic_request_frontend #(
    .DEBOUNCE_CYCLES(DEB),
    .EMERG_HOLD(HOLD),
    .MAX_SLOTS(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_ped_raw(btn_ped_raw),
    .siren_raw(siren_raw),
    .loop_car_raw(loop_car_raw),
    .gate_in_raw(gate_in_raw),
    .gate_out_raw(gate_out_raw),
    .pedestrian_green(pedestrian_green),
    .parking_slots(parking_slots),
    .pedestrian_req(pedestrian_req),
    .emergency(emergency),
    .car_sensor(car_sensor),
    .car_enter(car_enter),
    .car_exit(car_exit),
    .parking_full(parking_full)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] outs();
    return {pedestrian_req, emergency, car_sensor,
            car_enter, car_exit, parking_full};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    btn_ped_raw = 0; siren_raw = 0; loop_car_raw = 0;
    gate_in_raw = 0; gate_out_raw = 0;
    pedestrian_green = 0; parking_slots = 4'd5;
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 000000", outs());
    end
    reset_n = 1'b1;
    tick(3);
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL post_reset_outs: got %b want 000000", outs());
    end
  endtask

  task automatic test_pedestrian();
    btn_ped_raw = 1'b1;
    tick(LAT);
    checks++;
    if (pedestrian_req !== 1'b0) begin
      errors++;
      $display("FAIL ped_early: got %b want 0", pedestrian_req);
    end
    tick();
    checks++;
    if (pedestrian_req !== 1'b1) begin
      errors++;
      $display("FAIL ped_assert: got %b want 1", pedestrian_req);
    end
    tick(3);
    checks++;
    if (pedestrian_req !== 1'b1) begin
      errors++;
      $display("FAIL ped_held: got %b want 1", pedestrian_req);
    end
    pedestrian_green = 1'b1;
    tick();
    checks++;
    if (pedestrian_req !== 1'b0) begin
      errors++;
      $display("FAIL ped_ack: got %b want 0", pedestrian_req);
    end
    btn_ped_raw = 1'b0;
    tick(10);
    btn_ped_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (pedestrian_req !== 1'b0) begin
        errors++;
        $display("FAIL ped_requeue c%0d: got %b want 0", i, pedestrian_req);
      end
    end
    pedestrian_green = 1'b0;
    tick(4);
    checks++;
    if (pedestrian_req !== 1'b0) begin
      errors++;
      $display("FAIL ped_idle: got %b want 0", pedestrian_req);
    end
    btn_ped_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    siren_raw = 1'b1;
    loop_car_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen += int'(emergency);
    end
    siren_raw = 1'b0;
    loop_car_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen += int'(emergency | car_sensor);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL glitch: got %0d high cycles want 0", seen);
    end
    loop_car_raw = 1'b1;
    tick(LAT + 1);
    checks++;
    if (car_sensor !== 1'b1) begin
      errors++;
      $display("FAIL car_sensor: got %b want 1", car_sensor);
    end
    loop_car_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_parking_gate();
    int n_in, n_out;
    n_in = 0;
    n_out = 0;
    parking_slots = 4'd0;
    gate_in_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_in += int'(car_enter);
    end
    checks++;
    if (n_in != 0) begin
      errors++;
      $display("FAIL full_enter: got %0d pulses want 0", n_in);
    end
    checks++;
    if (parking_full !== 1'b1) begin
      errors++;
      $display("FAIL parking_full: got %b want 1", parking_full);
    end
    gate_in_raw = 1'b0;
    tick(10);
    parking_slots = 4'd10;
    gate_out_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_out += int'(car_exit);
    end
    checks++;
    if (n_out != 0) begin
      errors++;
      $display("FAIL max_exit: got %0d pulses want 0", n_out);
    end
    checks++;
    if (parking_full !== 1'b0) begin
      errors++;
      $display("FAIL parking_notfull: got %b want 0", parking_full);
    end
    gate_out_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_parking_pulse();
    parking_slots = 4'd5;
    gate_in_raw = 1'b1;
    tick(LAT);
    checks++;
    if (car_enter !== 1'b0) begin
      errors++;
      $display("FAIL enter_early: got %b want 0", car_enter);
    end
    tick();
    checks++;
    if ({car_enter, car_exit} !== 2'b10) begin
      errors++;
      $display("FAIL enter_pulse: got %b want 10", {car_enter, car_exit});
    end
    tick();
    checks++;
    if (car_enter !== 1'b0) begin
      errors++;
      $display("FAIL enter_width: got %b want 0", car_enter);
    end
    gate_in_raw = 1'b0;
    tick(10);
    gate_out_raw = 1'b1;
    tick(LAT + 1);
    checks++;
    if ({car_enter, car_exit} !== 2'b01) begin
      errors++;
      $display("FAIL exit_pulse: got %b want 01", {car_enter, car_exit});
    end
    tick();
    checks++;
    if (car_exit !== 1'b0) begin
      errors++;
      $display("FAIL exit_width: got %b want 0", car_exit);
    end
    gate_out_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_back_to_back();
    parking_slots = 4'd5;
    gate_in_raw = 1'b1;
    gate_out_raw = 1'b1;
    tick(LAT + 1);
    checks++;
    if ({car_enter, car_exit} !== 2'b10) begin
      errors++;
      $display("FAIL simul_n: got %b want 10", {car_enter, car_exit});
    end
    tick();
    checks++;
    if ({car_enter, car_exit} !== 2'b01) begin
      errors++;
      $display("FAIL simul_n1: got %b want 01", {car_enter, car_exit});
    end
    tick();
    checks++;
    if ({car_enter, car_exit} !== 2'b00) begin
      errors++;
      $display("FAIL simul_n2: got %b want 00", {car_enter, car_exit});
    end
    gate_in_raw = 1'b0;
    gate_out_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_emerg_hold();
    int fall_at;
`ifdef FRONTEND_EMERG_HOLD_EN
    fall_at = LAT + HOLD + 1;
`else
    fall_at = LAT + 1;
`endif
    siren_raw = 1'b1;
    tick(LAT + 1);
    checks++;
    if (emergency !== 1'b1) begin
      errors++;
      $display("FAIL emerg_rise: got %b want 1", emergency);
    end
    tick(20 - LAT - 1);
    siren_raw = 1'b0;
    tick(fall_at - 1);
    checks++;
    if (emergency !== 1'b1) begin
      errors++;
      $display("FAIL emerg_before_fall: got %b want 1", emergency);
    end
    tick();
    checks++;
    if (emergency !== 1'b0) begin
      errors++;
      $display("FAIL emerg_fall: got %b want 0", emergency);
    end
    tick(5);
  endtask

  task automatic test_reset_mid();
    btn_ped_raw = 1'b1;
    siren_raw = 1'b1;
    tick(LAT + 1);
    checks++;
    if ({pedestrian_req, emergency} !== 2'b11) begin
      errors++;
      $display("FAIL mid_setup: got %b want 11",
               {pedestrian_req, emergency});
    end
    siren_raw = 1'b0;
    tick(LAT + 2);
    btn_ped_raw = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want 000000", outs());
    end
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if ({pedestrian_req, emergency} !== 2'b00) begin
        errors++;
        $display("FAIL after_reset c%0d: got %b want 00", i,
                 {pedestrian_req, emergency});
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    do_reset();
    test_pedestrian();
    test_glitch();
    test_parking_gate();
    test_parking_pulse();
    test_back_to_back();
    do_reset();
    test_emerg_hold();
    do_reset();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_request_frontend.md
# traffic_request_frontend

Input conditioning front-end that produces the request and parking-event inputs consumed by `smart_traffic_controller`. It synchronizes and debounces raw field signals: pedestrian push-button, siren detector, road loop detector, and car-park entry/exit gate beams. It holds the pedestrian request until the controller answers with `pedestrian_green`, and converts gate beams into single-cycle `car_enter` / `car_exit` pulses gated by the controller's `parking_slots`. It sits between the board pins and the controller, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized cycles needed before a filtered level changes (≥2).
- `EMERG_HOLD`, 8: cycles `emergency` stays high after the filtered siren falls (only with the hold feature).
- `MAX_SLOTS`, 10: car-park capacity; must match the controller.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_ped_raw`  in  1  pedestrian push-button, asynchronous.
- `siren_raw`  in  1  siren detector, asynchronous.
- `loop_car_raw`  in  1  road loop detector, asynchronous.
- `gate_in_raw`  in  1  entry gate beam, asynchronous.
- `gate_out_raw`  in  1  exit gate beam, asynchronous.
- `pedestrian_green`  in  1  controller acknowledge; pedestrian phase is active.
- `parking_slots`  in  4  free slots reported by the controller.
- `pedestrian_req`  out  1  held pedestrian request.
- `emergency`  out  1  emergency request.
- `car_sensor`  out  1  filtered loop-detector level.
- `car_enter`  out  1  one-cycle entry pulse.
- `car_exit`  out  1  one-cycle exit pulse.
- `parking_full`  out  1  registered `parking_slots == 0`.

## Operation
- Each raw input passes through a 2-flop synchronizer, then its own debouncer.
- Debouncer behaviour:
  - The counter increments each cycle the synchronized value differs from the filtered level.
  - The counter clears whenever they match.
  - On the cycle the count reaches `DEBOUNCE_CYCLES` while still different, the filtered level flips and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` never change the filtered level.
- The pedestrian FSM has three states:
  - `P_IDLE` → `P_PENDING` on a filtered button rising edge.
  - `P_PENDING` → `P_SERVING` when `pedestrian_green`=1.
  - `P_SERVING` → `P_IDLE` when `pedestrian_green`=0.
  - `pedestrian_req`=1 only in `P_PENDING`.
  - Button edges are ignored in `P_PENDING` (already queued) and in `P_SERVING` (no re-queue from the same press).
- `car_sensor` is the filtered loop level, registered.
- `car_enter` is a pulse on a filtered `gate_in` rising edge. It is suppressed when `parking_slots == 0`.
- `car_exit` is a pulse on a filtered `gate_out` rising edge. It is suppressed when `parking_slots >= MAX_SLOTS`.
- Simultaneous entry and exit rising edges:
  - `car_enter` is pulsed this cycle.
  - The exit is latched in `exit_pending` and `car_exit` is pulsed the next cycle, with the suppression rule evaluated then.
  - The controller never sees both in one cycle.
- If a new exit edge arrives while `exit_pending`=1, the two exits merge into one pulse. This is a documented loss; at most one car per cycle is physically possible.
- Emergency hold, when compiled in: see Configuration.

## Timing
- Reset (`reset_n`=0, asynchronous) forces the following values to 0:
  - all outputs;
  - synchronizers and filtered levels;
  - debounce and hold counters;
  - `exit_pending`.
  - The FSM goes to `P_IDLE`.
- Release is synchronous to the next `clk` edge through the normal path; no extra reset synchronizer is inside.
- All outputs are registered.
- With the raw input stable from before edge k:
  - The synchronized value updates at edge k+1.
  - The filtered level updates at edge k+1+`DEBOUNCE_CYCLES`.
  - The output updates at edge k+2+`DEBOUNCE_CYCLES`, i.e. `DEBOUNCE_CYCLES`+2 edges after the first edge that samples the raw value.
- `pedestrian_req` falls on the edge after `pedestrian_green` is sampled high.
- `car_enter` / `car_exit` are exactly one cycle wide.
- Reset mid-request drops a pending pedestrian request. Reset mid-hold drops the emergency.

## Configuration
- Macro: `FRONTEND_EMERG_HOLD_EN`.
- Defined:
  - `emergency` = filtered siren OR (hold counter ≠ 0).
  - On a filtered siren falling edge the hold counter loads `EMERG_HOLD` and decrements each cycle to 0.
  - A siren rise during the hold keeps `emergency` high and clears the counter.
- Undefined:
  - `emergency` = filtered siren, registered.
  - No hold counter is present and `EMERG_HOLD` is unused.

## Structure
- Shared package `traffic_pkg` holds:
  - the pedestrian FSM state typedef (`P_IDLE`, `P_PENDING`, `P_SERVING`);
  - the `MAX_SLOTS` default constant;
  - the traffic-light code constants (RED=00, YELLOW=01, GREEN=10) shared with the controller.
- One sub-module, `input_debouncer`, containing the 2-flop synchronizer, counter and filtered level, parameterized by `DEBOUNCE_CYCLES`. It is instantiated five times.

## Test plan
- Pedestrian request and acknowledge, `DEBOUNCE_CYCLES`=4:
  - Stimulus: `btn_ped_raw` rises and is held 10 cycles.
  - Required: `pedestrian_req`=1 six edges after the first sampling edge.
  - Stimulus: `pedestrian_green` driven 1.
  - Required: `pedestrian_req`=0 next edge.
  - Stimulus: a second press while `pedestrian_green`=1.
  - Required: no re-assert.
- Glitch rejection: a 3-cycle pulse on `siren_raw` → `emergency` stays 0 throughout.
- Parking gating:
  - `parking_slots`=0 with a clean `gate_in_raw` rise → no `car_enter`.
  - `parking_slots`=10 with a `gate_out_raw` rise → no `car_exit`.
  - `parking_slots`=5 → each produces exactly one 1-cycle pulse.
- Simultaneous gates: both rise together with `parking_slots`=5 → `car_enter` on cycle n and `car_exit` on cycle n+1, never overlapping.
- Emergency hold, with `FRONTEND_EMERG_HOLD_EN` defined and `EMERG_HOLD`=8: siren held 20 cycles then released → `emergency` stays 1 for 8 cycles after the filtered fall, then 0. Without the macro, `emergency` falls on the edge after the filtered fall.
- Reset mid-operation: `reset_n` pulled low while `P_PENDING` and the hold counter is non-zero → all outputs read 0 immediately (asynchronous), and no request resumes after release.
